// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with memory-ack timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    input  logic             breq,
    input  logic             brlt,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [31:0]      ir,
    output logic             ir_wen,
    output logic             pc_wen,
    output logic             pc_sel,
    output logic [2:0]       wb_sel,
    output logic [2:0]       imm_op,
    output logic [3:0]       alu_op,
    output logic             rf_wen,
    output logic             brun,
    output logic             alua_sel,
    output logic             alub_sel,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic             bus_err
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TMO_LAST = WW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t            r_state;
    logic [31:0]       r_ir;
    logic [CNT_W-1:0]  r_instret;
    logic              r_bus_err;
    logic [WW-1:0]     r_wait;
    logic              r_br_taken;

    // Decode is driven straight off the instruction register, so it holds
    // steady from DECODE until the next fetch overwrites ir.
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_f7_alt;
    logic       w_is_r, w_is_i, w_is_ld, w_is_jalr, w_is_st, w_is_br;
    logic       w_is_lui, w_is_auipc, w_is_jal, w_legal;
    logic       w_taken, w_tmo;
    logic       w_in_fetch, w_in_mem, w_in_wb;

    assign w_opc      = r_ir[6:0];
    assign w_f3       = r_ir[14:12];
    assign w_f7_alt   = (r_ir[31:25] == 7'b0100000);
    assign w_is_r     = (w_opc == OP_R);
    assign w_is_i     = (w_opc == OP_I);
    assign w_is_ld    = (w_opc == OP_LOAD);
    assign w_is_jalr  = (w_opc == OP_JALR);
    assign w_is_st    = (w_opc == OP_STORE);
    assign w_is_br    = (w_opc == OP_BR);
    assign w_is_lui   = (w_opc == OP_LUI);
    assign w_is_auipc = (w_opc == OP_AUIPC);
    assign w_is_jal   = (w_opc == OP_JAL);
    assign w_legal    = w_is_r | w_is_i | w_is_ld | w_is_jalr | w_is_st | w_is_br |
                        w_is_lui | w_is_auipc | w_is_jal;

    always_comb begin
        alu_op = 4'd0;
        if (w_is_r || w_is_i) begin
            case (w_f3)
                3'b000:  alu_op = (w_is_r && w_f7_alt) ? 4'd1 : 4'd0;
                3'b001:  alu_op = 4'd5;
                3'b100:  alu_op = 4'd4;
                3'b101:  alu_op = w_f7_alt ? 4'd7 : 4'd6;
                3'b110:  alu_op = 4'd3;
                3'b111:  alu_op = 4'd2;
                default: alu_op = 4'd0;
            endcase
        end
    end

    always_comb begin
        imm_op = 3'd0;
        if (w_is_i || w_is_ld || w_is_jalr) imm_op = 3'd1;
        else if (w_is_st)                   imm_op = 3'd2;
        else if (w_is_br)                   imm_op = 3'd3;
        else if (w_is_lui || w_is_auipc)    imm_op = 3'd4;
        else if (w_is_jal)                  imm_op = 3'd5;
    end

    always_comb begin
        wb_sel = 3'd1;
        if (w_is_jal || w_is_jalr)                                wb_sel = 3'd0;
        else if (w_is_ld)                                         wb_sel = 3'd2;
        else if (w_is_lui)                                        wb_sel = 3'd3;
        else if ((w_is_r || w_is_i) && (w_f3[2:1] == 2'b01))      wb_sel = 3'd4;
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = breq;
            3'b001:  w_taken = ~breq;
            3'b100,
            3'b110:  w_taken = brlt;
            3'b101,
            3'b111:  w_taken = ~brlt;
            default: w_taken = 1'b0;
        endcase
    end

    assign brun     = ((w_is_r || w_is_i) && (w_f3 == 3'b011)) ||
                      (w_is_br && (w_f3[2:1] == 2'b11));
    assign alua_sel = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_jalr;
    assign alub_sel = w_is_r;
    assign w_tmo    = (ACK_TIMEOUT != 0) && (r_wait == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_ir       <= '0;
            r_instret  <= '0;
            r_bus_err  <= 1'b0;
            r_wait     <= '0;
            r_br_taken <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_wait  <= '0;
                        r_state <= S_DECODE;
                    end else if (w_tmo) begin
                        r_wait    <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_TRAP;
                    end else if (ACK_TIMEOUT != 0) begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    r_state <= w_legal ? S_EXEC : S_TRAP;
`else
                    r_state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    r_br_taken <= w_taken;
                    r_state    <= (w_is_ld || w_is_st) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_wait <= '0;
                        if (w_is_st) begin
                            r_instret <= r_instret + CNT_W'(1);
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_tmo) begin
                        r_wait    <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_TRAP;
                    end else if (ACK_TIMEOUT != 0) begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    r_instret <= r_instret + CNT_W'(1);
                    r_state   <= S_FETCH;
                end
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Enables are gated by rst_n so an in-flight request drops the moment reset asserts.
    assign w_in_fetch = rst_n && (r_state == S_FETCH);
    assign w_in_mem   = rst_n && (r_state == S_MEM);
    assign w_in_wb    = rst_n && (r_state == S_WB);

    assign mem_req  = w_in_fetch | w_in_mem;
    assign mem_we   = w_in_mem & w_is_st;
    assign addr_sel = w_in_mem;
    assign ir_wen   = w_in_fetch & mem_ack;
    assign pc_wen   = w_in_wb | (w_in_mem & mem_ack & w_is_st);
    assign rf_wen   = w_in_wb & w_legal & ~w_is_br;
    assign pc_sel   = w_is_jal | w_is_jalr | (w_is_br & r_br_taken);
    assign ir       = r_ir;
    assign instret  = r_instret;
    assign trap     = (r_state == S_TRAP);
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; built with ACK_TIMEOUT=4 and a 4-bit retire counter.
module tb_multicycle_control;
    localparam int CW = 4;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h00012083;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] BNE  = 32'h00209463;
    localparam logic [31:0] BGE  = 32'h0020D463;
    localparam logic [31:0] BLTU = 32'h0020E463;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] ILL  = 32'h0000007F;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0, breq = 1'b0, brlt = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_wen, pc_wen, pc_sel, rf_wen, brun;
    logic          alua_sel, alub_sel, trap, bus_err;
    logic [31:0]   ir;
    logic [2:0]    wb_sel, imm_op;
    logic [3:0]    alu_op;
    logic [CW-1:0] instret;

    int errors = 0, checks = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          c_rf_wen, c_pc_wen, c_pc_sel, c_brun, c_alua, c_alub;
    logic [2:0]    c_wb_sel, c_imm_op;
    logic [3:0]    c_alu_op;

    typedef struct {
        logic [31:0] insn; logic [2:0] wb; logic [3:0] alu; logic [2:0] imm;
        logic brun; logic alua; logic alub; logic pcsel;
    } vec_t;

    multicycle_control #(.ACK_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .breq(breq), .brlt(brlt), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir(ir), .ir_wen(ir_wen), .pc_wen(pc_wen),
        .pc_sel(pc_sel), .wb_sel(wb_sel), .imm_op(imm_op), .alu_op(alu_op),
        .rf_wen(rf_wen), .brun(brun), .alua_sel(alua_sel), .alub_sel(alub_sel),
        .instret(instret), .trap(trap), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // One FSM cycle: drive inputs just after the falling edge, settle, then sample.
    task automatic step(input logic ack, input logic [31:0] rd, input logic eq, input logic lt);
        @(negedge clk);
        mem_ack = ack; mem_rdata = rd; breq = eq; brlt = lt;
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #2;
        rst_n = 1'b0; mem_ack = 1'b0; breq = 1'b0; brlt = 1'b0; mem_rdata = '0;
        exp_ret = '0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Zero-wait non-memory instruction; leaves the bench in the WB cycle with outputs captured.
    task automatic run_insn(input logic [31:0] insn, input logic eq, input logic lt);
        step(1'b1, insn, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, eq, lt);
        step(1'b0, '0, 1'b0, 1'b0);
        c_rf_wen = rf_wen; c_pc_wen = pc_wen; c_pc_sel = pc_sel; c_brun = brun;
        c_alua = alua_sel; c_alub = alub_sel; c_wb_sel = wb_sel; c_imm_op = imm_op;
        c_alu_op = alu_op;
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0d exp=0", mem_req); end
        checks++; if (instret !== '0) begin errors++; $display("FAIL rst_instret got=%0d exp=0", instret); end
        checks++; if (trap !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_trap got=%0d/%0d exp=0/0", trap, bus_err); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir got=%h exp=0", ir); end
        @(posedge clk); #2; rst_n = 1'b1; #1;
        checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0) begin errors++; $display("FAIL rst_release_fetch got req=%0d asel=%0d exp 1/0", mem_req, addr_sel); end
    endtask

    task automatic test_alu_add;
        step(1'b1, ADD, 1'b0, 1'b0);
        checks++; if (ir_wen !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL add_c1_ir_wen got=%0d we=%0d exp 1/0", ir_wen, mem_we); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (ir !== ADD || ir_wen !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL add_decode got ir=%h wen=%0d req=%0d", ir, ir_wen, mem_req); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (rf_wen !== 1'b0 || pc_wen !== 1'b0) begin errors++; $display("FAIL add_exec got rf=%0d pc=%0d exp 0/0", rf_wen, pc_wen); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (rf_wen !== 1'b1 || pc_wen !== 1'b1 || wb_sel !== 3'd1 || alu_op !== 4'd0) begin errors++; $display("FAIL add_wb got rf=%0d pc=%0d wb=%0d alu=%0d exp 1/1/1/0", rf_wen, pc_wen, wb_sel, alu_op); end
        checks++; if (instret !== 4'd0) begin errors++; $display("FAIL add_wb_instret got=%0d exp=0", instret); end
        exp_ret = exp_ret + 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret || mem_req !== 1'b1) begin errors++; $display("FAIL add_retire got=%0d req=%0d exp=%0d/1", instret, mem_req, exp_ret); end
    endtask

    task automatic test_decode_table;
        vec_t v[14];
        v[0]  = '{32'h402081B3, 3'd1, 4'd1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // sub
        v[1]  = '{32'h4020D1B3, 3'd1, 4'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // sra
        v[2]  = '{32'h4010D093, 3'd1, 4'd7, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0}; // srai
        v[3]  = '{32'h0010D093, 3'd1, 4'd6, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0}; // srli
        v[4]  = '{32'h00513093, 3'd4, 4'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // sltiu
        v[5]  = '{32'h0020A1B3, 3'd4, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // slt
        v[6]  = '{32'h00114093, 3'd1, 4'd4, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0}; // xori
        v[7]  = '{32'h0020F1B3, 3'd1, 4'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // and
        v[8]  = '{32'h0020E1B3, 3'd1, 4'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // or
        v[9]  = '{32'h002091B3, 3'd1, 4'd5, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0}; // sll
        v[10] = '{32'h008000EF, 3'd0, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1}; // jal
        v[11] = '{32'h000080E7, 3'd0, 4'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1}; // jalr
        v[12] = '{32'h123450B7, 3'd3, 4'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0}; // lui
        v[13] = '{32'h00001097, 3'd1, 4'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0}; // auipc
        for (int i = 0; i < 14; i++) begin
            run_insn(v[i].insn, 1'b0, 1'b0);
            checks++;
            if (c_wb_sel !== v[i].wb || c_alu_op !== v[i].alu || c_imm_op !== v[i].imm ||
                c_brun !== v[i].brun || c_alua !== v[i].alua || c_alub !== v[i].alub ||
                c_pc_sel !== v[i].pcsel || c_rf_wen !== 1'b1 || c_pc_wen !== 1'b1) begin
                errors++;
                $display("FAIL decode_%h got wb=%0d alu=%0d imm=%0d brun=%0d a=%0d b=%0d pcs=%0d rf=%0d pw=%0d exp wb=%0d alu=%0d imm=%0d brun=%0d a=%0d b=%0d pcs=%0d rf=1 pw=1",
                         v[i].insn, c_wb_sel, c_alu_op, c_imm_op, c_brun, c_alua, c_alub, c_pc_sel, c_rf_wen, c_pc_wen,
                         v[i].wb, v[i].alu, v[i].imm, v[i].brun, v[i].alua, v[i].alub, v[i].pcsel);
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret) begin errors++; $display("FAIL decode_instret got=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_branch;
        run_insn(BNE, 1'b1, 1'b0);
        checks++; if (c_pc_sel !== 1'b0 || c_rf_wen !== 1'b0 || c_pc_wen !== 1'b1 || c_imm_op !== 3'd3) begin errors++; $display("FAIL bne_eq got pcs=%0d rf=%0d pw=%0d imm=%0d exp 0/0/1/3", c_pc_sel, c_rf_wen, c_pc_wen, c_imm_op); end
        run_insn(BGE, 1'b0, 1'b0);
        checks++; if (c_pc_sel !== 1'b1 || c_brun !== 1'b0 || c_rf_wen !== 1'b0) begin errors++; $display("FAIL bge_ge got pcs=%0d brun=%0d rf=%0d exp 1/0/0", c_pc_sel, c_brun, c_rf_wen); end
        run_insn(BLTU, 1'b0, 1'b1);
        checks++; if (c_pc_sel !== 1'b1 || c_brun !== 1'b1) begin errors++; $display("FAIL bltu_lt got pcs=%0d brun=%0d exp 1/1", c_pc_sel, c_brun); end
        run_insn(BEQ, 1'b0, 1'b1);
        checks++; if (c_pc_sel !== 1'b0) begin errors++; $display("FAIL beq_ne got pcs=%0d exp 0", c_pc_sel); end
    endtask

    task automatic test_load_wait;
        int nreq;
        nreq = 0;
        step(1'b1, LW, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        checks++; if (mem_req !== 1'b0 || ir_wen !== 1'b0 || ir !== LW) begin errors++; $display("FAIL lw_decode_ack_ignored got req=%0d wen=%0d ir=%h", mem_req, ir_wen, ir); end
        step(1'b1, '0, 1'b0, 1'b0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_exec_req got=%0d exp=0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            step(i == 3, '0, 1'b0, 1'b0);
            if (mem_req === 1'b1) nreq++;
            checks++; if (addr_sel !== 1'b1 || mem_we !== 1'b0 || wb_sel !== 3'd2 || rf_wen !== 1'b0) begin errors++; $display("FAIL lw_mem%0d got asel=%0d we=%0d wb=%0d rf=%0d exp 1/0/2/0", i, addr_sel, mem_we, wb_sel, rf_wen); end
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL lw_req_cycles got=%0d exp=4", nreq); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (rf_wen !== 1'b1 || pc_wen !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL lw_wb_c8 got rf=%0d pw=%0d req=%0d exp 1/1/0", rf_wen, pc_wen, mem_req); end
        exp_ret = exp_ret + 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret || addr_sel !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL lw_retire got ret=%0d asel=%0d req=%0d exp %0d/0/1", instret, addr_sel, mem_req, exp_ret); end
    endtask

    task automatic test_store;
        step(1'b1, SW, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || addr_sel !== 1'b1 || pc_wen !== 1'b1 || rf_wen !== 1'b0 || imm_op !== 3'd2) begin errors++; $display("FAIL sw_mem_c4 got req=%0d we=%0d asel=%0d pw=%0d rf=%0d imm=%0d exp 1/1/1/1/0/2", mem_req, mem_we, addr_sel, pc_wen, rf_wen, imm_op); end
        exp_ret = exp_ret + 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret || mem_we !== 1'b0 || addr_sel !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL sw_retire got ret=%0d we=%0d asel=%0d req=%0d exp %0d/0/0/1", instret, mem_we, addr_sel, mem_req, exp_ret); end
    endtask

    task automatic test_illegal;
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(1'b1, ILL, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL ill_decode_trap got=%0d exp=0", trap); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (trap !== 1'b1 || bus_err !== 1'b0 || mem_req !== 1'b0 || pc_wen !== 1'b0) begin errors++; $display("FAIL ill_trap got trap=%0d berr=%0d req=%0d pw=%0d exp 1/0/0/0", trap, bus_err, mem_req, pc_wen); end
        do_reset();
`else
        run_insn(ILL, 1'b0, 1'b0);
        checks++; if (c_rf_wen !== 1'b0 || c_pc_sel !== 1'b0 || c_pc_wen !== 1'b1) begin errors++; $display("FAIL ill_nop got rf=%0d pcs=%0d pw=%0d exp 0/0/1", c_rf_wen, c_pc_sel, c_pc_wen); end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret || trap !== 1'b0) begin errors++; $display("FAIL ill_nop_retire got ret=%0d trap=%0d exp %0d/0", instret, trap, exp_ret); end
`endif
    endtask

    task automatic test_timeout;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++; if (mem_req !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got req=%0d trap=%0d exp 1/0", i, mem_req, trap); end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (trap !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL tmo_trap got trap=%0d berr=%0d req=%0d exp 1/1/0", trap, bus_err, mem_req); end
        step(1'b1, ADD, 1'b0, 1'b0);
        step(1'b1, ADD, 1'b0, 1'b0);
        checks++; if (trap !== 1'b1 || mem_req !== 1'b0 || ir_wen !== 1'b0 || pc_wen !== 1'b0 || rf_wen !== 1'b0) begin errors++; $display("FAIL tmo_sticky got trap=%0d req=%0d iw=%0d pw=%0d rf=%0d exp 1/0/0/0/0", trap, mem_req, ir_wen, pc_wen, rf_wen); end
        do_reset();
        #1;
        checks++; if (trap !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL tmo_cleared got trap=%0d berr=%0d req=%0d exp 0/0/1", trap, bus_err, mem_req); end
    endtask

    task automatic test_reset_mid_store;
        run_insn(ADD, 1'b0, 1'b0);
        step(1'b1, SW, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || instret !== 4'd1) begin errors++; $display("FAIL rmid_pre got req=%0d we=%0d ret=%0d exp 1/1/1", mem_req, mem_we, instret); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || instret !== 4'd0) begin errors++; $display("FAIL rmid_drop got req=%0d we=%0d ret=%0d exp 0/0/0", mem_req, mem_we, instret); end
        exp_ret = '0;
        @(posedge clk); #2; rst_n = 1'b1; #1;
        checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_fetch got req=%0d asel=%0d we=%0d exp 1/0/0", mem_req, addr_sel, mem_we); end
        run_insn(ADD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== exp_ret) begin errors++; $display("FAIL rmid_resume got ret=%0d exp=%0d", instret, exp_ret); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 15; i++) run_insn(ADD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== 4'hF) begin errors++; $display("FAIL wrap_max got=%0d exp=15", instret); end
        run_insn(ADD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (instret !== 4'h0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", instret); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_add();
        test_decode_table();
        test_branch();
        test_load_wait();
        test_store();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
